// File: rtl/interrupt_controller.sv
// Edge-triggered, maskable, fixed-priority interrupt controller feeding the hazard
// control unit. It presents one request at a time and does not nest handlers.
module interrupt_controller #(
  parameter int                    NUM_SRC    = 4,
  parameter int                    ADDR_WIDTH = 14,
  parameter logic [ADDR_WIDTH-1:0] VEC_BASE   = 14'h0004,
  parameter int                    VEC_STRIDE = 4,
  parameter logic [NUM_SRC-1:0]    MASK_RESET = 4'b0001
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic [NUM_SRC-1:0]    irq_src,
  input  logic                  mask_we,
  input  logic [NUM_SRC-1:0]    mask_din,
  output logic [NUM_SRC-1:0]    irq_mask,
  output logic [NUM_SRC-1:0]    irq_pending,
  output logic                  interrupt,
  output logic [ADDR_WIDTH-1:0] interrupt_vector_address,
  input  logic                  int_ack,
  input  logic                  int_return,
  output logic                  in_service,
  output logic [2:0]            active_id
);

  // Handshake: interrupt rises in REQUEST and holds with a stable active_id/vector
  // until a one-cycle int_ack; int_return then closes SERVICE. Strobes seen in any
  // other state are ignored, and int_ack takes precedence over a coincident return.
  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_SERVICE} state_t;

  localparam logic [NUM_SRC-1:0] LP_SRC0 = {{(NUM_SRC-1){1'b0}}, 1'b1};

  state_t                  r_state;
  logic [NUM_SRC-1:0]      r_src_q;
  logic [NUM_SRC-1:0]      r_pending;
  logic [NUM_SRC-1:0]      r_mask;
  logic                    r_interrupt;
  logic [ADDR_WIDTH-1:0]   r_vec;
  logic                    r_in_service;
  logic [2:0]              r_active_id;

  logic [NUM_SRC-1:0]      w_rise;
  logic [NUM_SRC-1:0]      w_elig;
  logic [NUM_SRC-1:0]      w_clr;
  logic                    w_ack_taken;
  logic [2:0]              w_win_id;
  logic [ADDR_WIDTH-1:0]   w_vec;

  assign w_rise      = irq_src & ~r_src_q;
  assign w_elig      = r_pending & (r_mask | LP_SRC0);
  assign w_ack_taken = (r_state == S_REQUEST) && int_ack;
  assign w_clr       = w_ack_taken ? (LP_SRC0 << r_active_id) : '0;

  // Lowest eligible index wins, so scan from the top down.
  always_comb begin
    w_win_id = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win_id = 3'(i);
    end
  end

  assign w_vec = VEC_BASE + ADDR_WIDTH'(32'(w_win_id) * VEC_STRIDE);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_src_q   <= '0;
      r_pending <= '0;
      r_mask    <= MASK_RESET;
    end else begin
      r_src_q   <= irq_src;
      // A new rise on the bit being acknowledged keeps it pending.
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (mask_we) r_mask <= mask_din;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state      <= S_IDLE;
      r_interrupt  <= 1'b0;
      r_vec        <= '0;
      r_in_service <= 1'b0;
      r_active_id  <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_elig) begin
            r_active_id <= w_win_id;
            r_vec       <= w_vec;
            r_interrupt <= 1'b1;
            r_state     <= S_REQUEST;
          end
        end
        S_REQUEST: begin
          if (int_ack) begin
            r_interrupt  <= 1'b0;
            r_in_service <= 1'b1;
            r_state      <= S_SERVICE;
          end
        end
        S_SERVICE: begin
          if (int_return) begin
            r_in_service <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_interrupt  <= 1'b0;
          r_in_service <= 1'b0;
        end
      endcase
    end
  end

  assign irq_mask                 = r_mask;
  assign irq_pending              = r_pending;
  assign interrupt                = r_interrupt;
  assign interrupt_vector_address = r_vec;
  assign in_service               = r_in_service;
  assign active_id                = r_active_id;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: expected {active_id, vector} pairs are
// queued when a source is stimulated and checked when interrupt is presented.
module tb_interrupt_controller;

  localparam int W = 17;

  logic        clock;
  logic        nreset;
  logic [3:0]  irq_src;
  logic        mask_we;
  logic [3:0]  mask_din;
  logic [3:0]  irq_mask;
  logic [3:0]  irq_pending;
  logic        interrupt;
  logic [13:0] interrupt_vector_address;
  logic        int_ack;
  logic        int_return;
  logic        in_service;
  logic [2:0]  active_id;

  logic [W-1:0] exp_q[$];
  int           n_chk;
  int           n_err;

  interrupt_controller dut (
    .clock                    (clock),
    .nreset                   (nreset),
    .irq_src                  (irq_src),
    .mask_we                  (mask_we),
    .mask_din                 (mask_din),
    .irq_mask                 (irq_mask),
    .irq_pending              (irq_pending),
    .interrupt                (interrupt),
    .interrupt_vector_address (interrupt_vector_address),
    .int_ack                  (int_ack),
    .int_return               (int_return),
    .in_service               (in_service),
    .active_id                (active_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [W-1:0] e;
    chk({tag, "_irq"}, 32'(interrupt), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_q_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_id_vec"}, 32'({active_id, interrupt_vector_address}), 32'(e));
    end
  endtask

  task automatic wait_irq(input string tag, input int budget);
    for (int i = 0; i < budget && !interrupt; i++) tick();
    sb_check(tag);
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we = 1'b1; mask_din = m;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic do_ret();
    int_return = 1'b1;
    tick();
    int_return = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] s);
    irq_src = s;
    tick();
    irq_src = 4'b0;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    nreset = 1'b0; irq_src = 4'b0; mask_we = 1'b0; mask_din = 4'b0;
    int_ack = 1'b0; int_return = 1'b0;
    tick(); tick();
    chk("rst_mask", 32'(irq_mask), 32'h1);
    chk("rst_pending", 32'(irq_pending), 32'h0);
    chk("rst_irq", 32'(interrupt), 32'h0);
    chk("rst_vec", 32'(interrupt_vector_address), 32'h0);
    chk("rst_insvc", 32'(in_service), 32'h0);
    chk("rst_id", 32'(active_id), 32'h0);
    nreset = 1'b1;
    tick();

    // Single source, exact latency, held request, acknowledge.
    write_mask(4'b0011);
    chk("t1_mask", 32'(irq_mask), 32'h3);
    exp_q.push_back({3'd1, 14'h0008});
    pulse(4'b0010);
    chk("t1_pending", 32'(irq_pending), 32'h2);
    chk("t1_irq_early", 32'(interrupt), 32'h0);
    tick();
    sb_check("t1");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_hold_irq", 32'(interrupt), 32'h1);
      chk("t1_hold_vec", 32'({active_id, interrupt_vector_address}), 32'({3'd1, 14'h0008}));
    end
    do_ack();
    chk("t1_ack_irq", 32'(interrupt), 32'h0);
    chk("t1_ack_insvc", 32'(in_service), 32'h1);
    chk("t1_ack_pending", 32'(irq_pending), 32'h0);
    do_ret();
    chk("t1_ret_insvc", 32'(in_service), 32'h0);

    // Two simultaneous rises: priority, then re-request one cycle after return.
    write_mask(4'b1111);
    exp_q.push_back({3'd1, 14'h0008});
    exp_q.push_back({3'd3, 14'h0010});
    pulse(4'b1010);
    wait_irq("t2a", 4);
    do_ack();
    do_ret();
    chk("t2_gap_irq", 32'(interrupt), 32'h0);
    tick();
    sb_check("t2b");
    do_ack();
    do_ret();

    // Masked source latches and fires once unmasked; source 0 ignores the mask.
    write_mask(4'b0000);
    pulse(4'b0100);
    chk("t3_pending", 32'(irq_pending), 32'h4);
    tick(); tick();
    chk("t3_masked_irq", 32'(interrupt), 32'h0);
    exp_q.push_back({3'd2, 14'h000C});
    write_mask(4'b0100);
    wait_irq("t3a", 4);
    do_ack();
    do_ret();
    write_mask(4'b0000);
    exp_q.push_back({3'd0, 14'h0004});
    pulse(4'b0001);
    wait_irq("t3b", 4);
    do_ack();

    // No nesting while in service; rise coinciding with ack stays pending.
    pulse(4'b0001);
    chk("t4_svc_pending", 32'(irq_pending), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_svc_irq", 32'(interrupt), 32'h0);
    end
    exp_q.push_back({3'd0, 14'h0004});
    do_ret();
    wait_irq("t4a", 4);
    irq_src = 4'b0001; int_ack = 1'b1;
    tick();
    irq_src = 4'b0; int_ack = 1'b0;
    chk("t4_same_insvc", 32'(in_service), 32'h1);
    chk("t4_same_pending", 32'(irq_pending), 32'h1);
    exp_q.push_back({3'd0, 14'h0004});
    do_ret();
    wait_irq("t4b", 4);
    do_ack();
    do_ret();

    // Held-high source gives exactly one request; spurious strobes ignored.
    write_mask(4'b0010);
    exp_q.push_back({3'd1, 14'h0008});
    irq_src = 4'b0010;
    tick();
    chk("t6_pending", 32'(irq_pending), 32'h2);
    tick();
    sb_check("t6");
    do_ret();
    chk("t6_spur_ret_irq", 32'(interrupt), 32'h1);
    chk("t6_spur_ret_insvc", 32'(in_service), 32'h0);
    chk("t6_spur_ret_id", 32'(active_id), 32'h1);
    do_ack();
    for (int i = 0; i < 15; i++) tick();
    chk("t6_held_pending", 32'(irq_pending), 32'h0);
    do_ret();
    tick();
    chk("t6_no_second_irq", 32'(interrupt), 32'h0);
    irq_src = 4'b0;
    do_ack();
    chk("t6_spur_ack_irq", 32'(interrupt), 32'h0);
    chk("t6_spur_ack_insvc", 32'(in_service), 32'h0);

    // Asynchronous reset in the middle of a request.
    write_mask(4'b1111);
    exp_q.push_back({3'd2, 14'h000C});
    pulse(4'b0100);
    wait_irq("t5", 4);
    pulse(4'b1000);
    chk("t5_pre_pending", 32'(irq_pending), 32'hC);
    #2 nreset = 1'b0;
    #1;
    chk("t5_rst_irq", 32'(interrupt), 32'h0);
    chk("t5_rst_pending", 32'(irq_pending), 32'h0);
    chk("t5_rst_insvc", 32'(in_service), 32'h0);
    chk("t5_rst_mask", 32'(irq_mask), 32'h1);
    tick();
    nreset = 1'b1;
    tick(); tick();
    chk("t5_post_irq", 32'(interrupt), 32'h0);
    chk("t5_q_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
